// File: rtl/axi_arb_pkg.sv
// Shared definitions for the AXI4 write-path arbiter: AXI encodings, AW FSM states
// and the master-index width helper.
package axi_arb_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        AW_ARB  = 1'b0,
        AW_HOLD = 1'b1
    } aw_state_e;

    // A single-bit index is kept even for two masters so vectors never collapse to zero width.
    function automatic int midx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axi_arb_wfifo.sv
// In-order W-routing FIFO: holds the master index of every granted AW whose W burst
// has not yet finished. The head is read combinationally from a register array.
module axi_arb_wfifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr_reg;
    logic [PTR_W:0]   rd_ptr_reg;
    logic             push_ok;
    logic             pop_ok;

    // Extra pointer bit distinguishes full from empty when the low bits coincide.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                     (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr_reg[PTR_W-1:0]];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/axi4_wr_arbiter.sv
// N:1 AXI4 write-path arbiter: round-robin AW grant, in-order W routing, B routed back
// by the master index carried in the ID MSBs. Define AXI_ARB_QOS_EN for QoS-priority AW.
module axi4_wr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int DATA_WIDTH  = 256,
    parameter int ADDR_WIDTH  = 32,
    parameter int ID_WIDTH    = 4,
    parameter int WFIFO_DEPTH = 4,
    localparam int MIDX_W     = midx_w(NUM_MASTERS),
    localparam int SID_W      = ID_WIDTH + MIDX_W,
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [NUM_MASTERS-1:0]          m_awvalid,
    output logic [NUM_MASTERS-1:0]          m_awready,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_awaddr,
    input  logic [NUM_MASTERS*ID_WIDTH-1:0] m_awid,
    input  logic [NUM_MASTERS*8-1:0]        m_awlen,
    input  logic [NUM_MASTERS*3-1:0]        m_awsize,
    input  logic [NUM_MASTERS*2-1:0]        m_awburst,
`ifdef AXI_ARB_QOS_EN
    input  logic [NUM_MASTERS*4-1:0]        m_awqos,
`endif
    input  logic [NUM_MASTERS-1:0]          m_wvalid,
    output logic [NUM_MASTERS-1:0]          m_wready,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    input  logic [NUM_MASTERS*STRB_W-1:0]   m_wstrb,
    input  logic [NUM_MASTERS-1:0]          m_wlast,
    output logic [NUM_MASTERS-1:0]          m_bvalid,
    input  logic [NUM_MASTERS-1:0]          m_bready,
    output logic [1:0]                      m_bresp,
    output logic [ID_WIDTH-1:0]             m_bid,
    output logic                            s_awvalid,
    input  logic                            s_awready,
    output logic [ADDR_WIDTH-1:0]           s_awaddr,
    output logic [SID_W-1:0]                s_awid,
    output logic [7:0]                      s_awlen,
    output logic [2:0]                      s_awsize,
    output logic [1:0]                      s_awburst,
`ifdef AXI_ARB_QOS_EN
    output logic [3:0]                      s_awqos,
`endif
    output logic                            s_wvalid,
    input  logic                            s_wready,
    output logic [DATA_WIDTH-1:0]           s_wdata,
    output logic [STRB_W-1:0]               s_wstrb,
    output logic                            s_wlast,
    input  logic                            s_bvalid,
    output logic                            s_bready,
    input  logic [1:0]                      s_bresp,
    input  logic [SID_W-1:0]                s_bid,
    output logic                            wfifo_full,
    output logic                            b_decerr
);

    logic [ADDR_WIDTH-1:0] aw_addr_arr  [NUM_MASTERS];
    logic [ID_WIDTH-1:0]   aw_id_arr    [NUM_MASTERS];
    logic [7:0]            aw_len_arr   [NUM_MASTERS];
    logic [2:0]            aw_size_arr  [NUM_MASTERS];
    logic [1:0]            aw_burst_arr [NUM_MASTERS];
    logic [DATA_WIDTH-1:0] w_data_arr   [NUM_MASTERS];
    logic [STRB_W-1:0]     w_strb_arr   [NUM_MASTERS];
`ifdef AXI_ARB_QOS_EN
    logic [3:0]            aw_qos_arr   [NUM_MASTERS];
    logic [3:0]            best_qos;
    logic [MIDX_W-1:0]     qos_idx;
`endif

    aw_state_e         state_reg, state_next;
    logic [MIDX_W-1:0] grant_reg, grant_next;
    logic [MIDX_W-1:0] last_grant_reg, last_grant_next;
    logic [MIDX_W-1:0] rr_pick;
    logic [MIDX_W-1:0] rr_cand;
    logic              rr_found;
    logic              aw_hold;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [MIDX_W-1:0] w_head;
    logic [MIDX_W-1:0] b_idx;
    logic              b_idx_bad;

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
        assign aw_addr_arr[gi]  = m_awaddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign aw_id_arr[gi]    = m_awid[gi*ID_WIDTH +: ID_WIDTH];
        assign aw_len_arr[gi]   = m_awlen[gi*8 +: 8];
        assign aw_size_arr[gi]  = m_awsize[gi*3 +: 3];
        assign aw_burst_arr[gi] = m_awburst[gi*2 +: 2];
        assign w_data_arr[gi]   = m_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        assign w_strb_arr[gi]   = m_wstrb[gi*STRB_W +: STRB_W];
`ifdef AXI_ARB_QOS_EN
        assign aw_qos_arr[gi]   = m_awqos[gi*4 +: 4];
`endif
        assign m_awready[gi] = aw_hold && (grant_reg == MIDX_W'(gi)) && s_awready;
        assign m_wready[gi]  = !fifo_empty && (w_head == MIDX_W'(gi)) && s_wready;
        assign m_bvalid[gi]  = s_bvalid && (b_idx == MIDX_W'(gi));
    end

    // Scan starts one past last_grant, so the most recently served master is visited last.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_cand  = '0;
`ifdef AXI_ARB_QOS_EN
        best_qos = '0;
        qos_idx  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            qos_idx = MIDX_W'(i);
            if (m_awvalid[qos_idx] && (aw_qos_arr[qos_idx] > best_qos)) begin
                best_qos = aw_qos_arr[qos_idx];
            end
        end
`endif
        for (int off = 1; off <= NUM_MASTERS; off++) begin
            rr_cand = MIDX_W'((int'(last_grant_reg) + off) % NUM_MASTERS);
`ifdef AXI_ARB_QOS_EN
            if (!rr_found && m_awvalid[rr_cand] && (aw_qos_arr[rr_cand] == best_qos)) begin
`else
            if (!rr_found && m_awvalid[rr_cand]) begin
`endif
                rr_found = 1'b1;
                rr_pick  = rr_cand;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg      <= AW_ARB;
            grant_reg      <= '0;
            last_grant_reg <= MIDX_W'(NUM_MASTERS - 1);
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            AW_ARB: begin
                if (rr_found && !fifo_full) begin
                    grant_next = rr_pick;
                    state_next = AW_HOLD;
                end
            end
            AW_HOLD: begin
                // A master withdrawing AW valid mid-grant is dropped without a push.
                if (m_awvalid[grant_reg] && s_awready) begin
                    last_grant_next = grant_reg;
                    state_next      = AW_ARB;
                end else if (!m_awvalid[grant_reg]) begin
                    state_next = AW_ARB;
                end
            end
            default: state_next = AW_ARB;
        endcase
    end

    always_comb begin
        aw_hold   = (state_reg == AW_HOLD);
        s_awvalid = aw_hold && m_awvalid[grant_reg];
        fifo_push = s_awvalid && s_awready;
    end

    assign s_awaddr  = aw_addr_arr[grant_reg];
    assign s_awid    = {grant_reg, aw_id_arr[grant_reg]};
    assign s_awlen   = aw_len_arr[grant_reg];
    assign s_awsize  = aw_size_arr[grant_reg];
    assign s_awburst = aw_burst_arr[grant_reg];
`ifdef AXI_ARB_QOS_EN
    assign s_awqos   = aw_qos_arr[grant_reg];
`endif

    axi_arb_wfifo #(
        .DEPTH (WFIFO_DEPTH),
        .WIDTH (MIDX_W)
    ) u_wfifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (fifo_push),
        .push_data (grant_reg),
        .pop       (fifo_pop),
        .head      (w_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign wfifo_full = fifo_full;
    assign s_wvalid   = !fifo_empty && m_wvalid[w_head];
    assign s_wlast    = !fifo_empty && m_wlast[w_head];
    assign s_wdata    = w_data_arr[w_head];
    assign s_wstrb    = w_strb_arr[w_head];
    assign fifo_pop   = s_wvalid && s_wready && s_wlast;

    // Responses whose index names no master are accepted here so the slave never stalls.
    assign b_idx     = s_bid[SID_W-1:ID_WIDTH];
    assign b_idx_bad = (int'(b_idx) >= NUM_MASTERS);
    assign s_bready  = b_idx_bad ? 1'b1 : m_bready[b_idx];
    assign b_decerr  = s_bvalid && b_idx_bad;
    assign m_bid     = s_bid[ID_WIDTH-1:0];
    assign m_bresp   = s_bresp;

endmodule

// File: tb/tb_axi4_wr_arbiter.sv
// Scoreboard bench for axi4_wr_arbiter (4 masters) plus a 3-master instance for the
// out-of-range B index. Build with AXI_ARB_QOS_EN to add the QoS priority case.
module tb_axi4_wr_arbiter;

    logic        aclk;
    logic        aresetn;
    logic [3:0]  m_awvalid, m_awready;
    logic [127:0] m_awaddr;
    logic [15:0] m_awid;
    logic [31:0] m_awlen;
    logic [11:0] m_awsize;
    logic [7:0]  m_awburst;
`ifdef AXI_ARB_QOS_EN
    logic [15:0] m_awqos;
    logic [3:0]  s_awqos;
`endif
    logic [3:0]  m_wvalid, m_wready;
    logic [127:0] m_wdata;
    logic [15:0] m_wstrb;
    logic [3:0]  m_wlast;
    logic [3:0]  m_bvalid, m_bready;
    logic [1:0]  m_bresp;
    logic [3:0]  m_bid;
    logic        s_awvalid, s_awready;
    logic [31:0] s_awaddr;
    logic [5:0]  s_awid;
    logic [7:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst;
    logic        s_wvalid, s_wready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wlast;
    logic        s_bvalid, s_bready;
    logic [1:0]  s_bresp;
    logic [5:0]  s_bid;
    logic        wfifo_full, b_decerr;

    logic [2:0]  d3_awready, d3_wready, d3_bvalid, d3_bready;
    logic [1:0]  d3_bresp;
    logic [3:0]  d3_bid;
    logic        d3_awvalid_s, d3_wvalid_s, d3_wlast_s, d3_bready_s, d3_wfifo_full, d3_decerr;
    logic [31:0] d3_awaddr_s, d3_wdata_s;
    logic [5:0]  d3_awid_s;
    logic [7:0]  d3_awlen_s;
    logic [2:0]  d3_awsize_s;
    logic [1:0]  d3_awburst_s;
    logic [3:0]  d3_wstrb_s;
    logic        d3_s_bvalid;
    logic [5:0]  d3_s_bid;
`ifdef AXI_ARB_QOS_EN
    logic [3:0]  d3_awqos_s;
`endif

    int n_pass  = 0;
    int n_total = 0;
    logic [63:0] exp_aw[$];
    logic [63:0] exp_w[$];
    logic [63:0] exp_b[$];

    axi4_wr_arbiter #(
        .NUM_MASTERS(4), .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4), .WFIFO_DEPTH(4)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
        .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
`ifdef AXI_ARB_QOS_EN
        .m_awqos(m_awqos),
`endif
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_bid(m_bid), .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_awid(s_awid), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
`ifdef AXI_ARB_QOS_EN
        .s_awqos(s_awqos),
`endif
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_bid(s_bid), .wfifo_full(wfifo_full), .b_decerr(b_decerr)
    );

    axi4_wr_arbiter #(
        .NUM_MASTERS(3), .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4), .WFIFO_DEPTH(4)
    ) dut3 (
        .aclk(aclk), .aresetn(aresetn),
        .m_awvalid(3'b000), .m_awready(d3_awready), .m_awaddr(96'd0), .m_awid(12'd0),
        .m_awlen(24'd0), .m_awsize(9'd0), .m_awburst(6'd0),
`ifdef AXI_ARB_QOS_EN
        .m_awqos(12'd0),
`endif
        .m_wvalid(3'b000), .m_wready(d3_wready), .m_wdata(96'd0), .m_wstrb(12'd0),
        .m_wlast(3'b000), .m_bvalid(d3_bvalid), .m_bready(d3_bready), .m_bresp(d3_bresp),
        .m_bid(d3_bid), .s_awvalid(d3_awvalid_s), .s_awready(1'b1), .s_awaddr(d3_awaddr_s),
        .s_awid(d3_awid_s), .s_awlen(d3_awlen_s), .s_awsize(d3_awsize_s), .s_awburst(d3_awburst_s),
`ifdef AXI_ARB_QOS_EN
        .s_awqos(d3_awqos_s),
`endif
        .s_wvalid(d3_wvalid_s), .s_wready(1'b1), .s_wdata(d3_wdata_s), .s_wstrb(d3_wstrb_s),
        .s_wlast(d3_wlast_s), .s_bvalid(d3_s_bvalid), .s_bready(d3_bready_s), .s_bresp(2'b00),
        .s_bid(d3_s_bid), .wfifo_full(d3_wfifo_full), .b_decerr(d3_decerr)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] aw_exp(input logic [1:0] m, input logic [3:0] id,
                                           input logic [31:0] addr, input logic [7:0] len);
        return {13'd0, addr, m, id, len, 3'd2, 2'b01};
    endfunction

    task automatic push_w(input logic [31:0] base, input int total, input int nsend);
        for (int b = 0; b < nsend; b++)
            exp_w.push_back({27'd0, base + 32'(b), 4'hF, (b == total - 1)});
    endtask

    task automatic aw_send(input logic [1:0] m, input logic [3:0] id,
                           input logic [31:0] addr, input logic [7:0] len);
        bit hs = 0;
        m_awvalid[m] = 1'b1;
        m_awaddr[m*32 +: 32] = addr;
        m_awid[m*4 +: 4]     = id;
        m_awlen[m*8 +: 8]    = len;
        m_awsize[m*3 +: 3]   = 3'd2;
        m_awburst[m*2 +: 2]  = 2'b01;
        for (int c = 0; c < 200 && !hs; c++) begin
            @(negedge aclk);
            hs = m_awready[m];
            @(posedge aclk);
            #1;
        end
        m_awvalid[m] = 1'b0;
        if (!hs) chk("aw_timeout", 64'd0, 64'd1);
    endtask

    task automatic w_send(input logic [1:0] m, input logic [31:0] base,
                          input int total, input int nsend);
        for (int b = 0; b < nsend; b++) begin
            bit hs = 0;
            m_wvalid[m] = 1'b1;
            m_wdata[m*32 +: 32] = base + 32'(b);
            m_wstrb[m*4 +: 4]   = 4'hF;
            m_wlast[m]          = (b == total - 1);
            for (int c = 0; c < 300 && !hs; c++) begin
                @(negedge aclk);
                hs = m_wready[m];
                @(posedge aclk);
                #1;
            end
            if (!hs) chk("w_timeout", 64'd0, 64'd1);
        end
        m_wvalid[m] = 1'b0;
        m_wlast[m]  = 1'b0;
    endtask

    // Monitor: pop the expected entry whenever a downstream handshake is about to occur.
    always @(negedge aclk) begin : monitor
        logic [63:0] e;
        if (aresetn) begin
            if (s_awvalid && s_awready) begin
                $display("aw  sid=%h addr=%h len=%0d", s_awid, s_awaddr, s_awlen);
                if (exp_aw.size() == 0) chk("aw_unexpected", 64'd1, 64'd0);
                else begin
                    e = exp_aw.pop_front();
                    chk("aw_fields", {13'd0, s_awaddr, s_awid, s_awlen, s_awsize, s_awburst}, e);
                end
            end
            if (s_wvalid && s_wready) begin
                $display("w   data=%h last=%b", s_wdata, s_wlast);
                if (exp_w.size() == 0) chk("w_unexpected", 64'd1, 64'd0);
                else begin
                    e = exp_w.pop_front();
                    chk("w_beat", {27'd0, s_wdata, s_wstrb, s_wlast}, e);
                end
            end
            if (s_bvalid && s_bready) begin
                $display("b   m_bvalid=%b bid=%h resp=%0d", m_bvalid, m_bid, m_bresp);
                if (exp_b.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
                else begin
                    e = exp_b.pop_front();
                    chk("b_route", {54'd0, m_bvalid, m_bid, m_bresp}, e);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0;
        m_awvalid = '0; m_awaddr = '0; m_awid = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0;
        m_wvalid = '0; m_wdata = '0; m_wstrb = '0; m_wlast = '0; m_bready = '0;
        s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b0; s_bresp = '0; s_bid = '0;
        d3_bready = '0; d3_s_bvalid = 1'b0; d3_s_bid = '0;
`ifdef AXI_ARB_QOS_EN
        m_awqos = '0;
`endif
        @(negedge aclk);
        chk("reset_outputs", {43'd0, m_awready, m_wready, m_bvalid, s_awvalid, s_wvalid,
                              wfifo_full, b_decerr, s_bready}, 64'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        #1;

        // Masters 0 and 2 together: grant 0 then 2, s_awvalid one cycle after request.
        exp_aw.push_back(aw_exp(2'd0, 4'h1, 32'h0000_0100, 8'd0));
        exp_aw.push_back(aw_exp(2'd2, 4'h7, 32'h0000_0200, 8'd0));
        push_w(32'h1000, 1, 1);
        push_w(32'h2000, 1, 1);
        fork
            aw_send(2'd0, 4'h1, 32'h0000_0100, 8'd0);
            aw_send(2'd2, 4'h7, 32'h0000_0200, 8'd0);
            begin
                @(negedge aclk); chk("aw_latency_c0", {63'd0, s_awvalid}, 64'd0);
                @(negedge aclk); chk("aw_latency_c1", {63'd0, s_awvalid}, 64'd1);
            end
        join
        fork
            w_send(2'd0, 32'h1000, 1, 1);
            w_send(2'd2, 32'h2000, 1, 1);
        join

        // Master 1 burst of 4 must fully drain before master 3's single beat.
        exp_aw.push_back(aw_exp(2'd1, 4'h2, 32'h0000_0300, 8'd3));
        exp_aw.push_back(aw_exp(2'd3, 4'h4, 32'h0000_0400, 8'd0));
        aw_send(2'd1, 4'h2, 32'h0000_0300, 8'd3);
        aw_send(2'd3, 4'h4, 32'h0000_0400, 8'd0);
        push_w(32'h3000, 4, 4);
        push_w(32'h4000, 1, 1);
        fork
            w_send(2'd3, 32'h4000, 1, 1);
            begin
                repeat (2) begin
                    @(negedge aclk);
                    chk("wready3_blocked", {63'd0, m_wready[3]}, 64'd0);
                    chk("wvalid_head_idle", {63'd0, s_wvalid}, 64'd0);
                end
                @(posedge aclk); #1;
                w_send(2'd1, 32'h3000, 4, 4);
            end
        join

        // Four outstanding grants fill the FIFO; a fifth AW waits for the first burst.
        s_wready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_aw.push_back(aw_exp(2'(i), 4'h5, 32'h0000_1000 + 32'(i), 8'd0));
            aw_send(2'(i), 4'h5, 32'h0000_1000 + 32'(i), 8'd0);
        end
        @(negedge aclk);
        chk("wfifo_full_set", {63'd0, wfifo_full}, 64'd1);
        @(posedge aclk); #1;
        exp_aw.push_back(aw_exp(2'd0, 4'h9, 32'h0000_2000, 8'd0));
        for (int i = 0; i < 4; i++) push_w(32'h5000 + 32'(i << 4), 1, 1);
        push_w(32'h6000, 1, 1);
        fork
            aw_send(2'd0, 4'h9, 32'h0000_2000, 8'd0);
            begin
                repeat (5) begin
                    @(negedge aclk);
                    chk("aw_stalled_full", {62'd0, s_awvalid, wfifo_full}, 64'd1);
                end
                @(posedge aclk); #1;
                s_wready = 1'b1;
                for (int i = 0; i < 4; i++) w_send(2'(i), 32'h5000 + 32'(i << 4), 1, 1);
                w_send(2'd0, 32'h6000, 1, 1);
            end
        join
        @(negedge aclk);
        chk("wfifo_drained", {63'd0, wfifo_full}, 64'd0);
        @(posedge aclk); #1;

        // B routing on the 4-master instance and out-of-range index on the 3-master one.
        s_bid = {2'd3, 4'hA}; s_bresp = 2'b00; s_bvalid = 1'b1; m_bready = 4'b1000;
        exp_b.push_back({54'd0, 4'b1000, 4'hA, 2'b00});
        d3_s_bid = {2'd3, 4'h5}; d3_s_bvalid = 1'b1; d3_bready = 3'b000;
        @(negedge aclk);
        chk("b_ready_m3", {62'd0, s_bready, b_decerr}, 64'd2);
        chk("d3_decerr", {58'd0, d3_bvalid, d3_bready_s, d3_decerr, d3_bid}, {58'd0, 3'b000, 1'b1, 1'b1, 4'h5});
        @(posedge aclk); #1;
        s_bid = {2'd1, 4'h5}; s_bresp = 2'b10; m_bready = 4'b1101;
        d3_s_bid = {2'd2, 4'h6}; d3_bready = 3'b100;
        @(negedge aclk);
        chk("b_backpressure", {57'd0, m_bvalid, s_bready, m_bresp}, {57'd0, 4'b0010, 1'b0, 2'b10});
        chk("d3_valid_idx", {59'd0, d3_bvalid, d3_bready_s, d3_decerr}, {59'd0, 3'b100, 1'b1, 1'b0});
        @(posedge aclk); #1;
        m_bready = 4'b0010;
        exp_b.push_back({54'd0, 4'b0010, 4'h5, 2'b10});
        d3_s_bvalid = 1'b0;
        @(negedge aclk);
        chk("d3_decerr_clear", {63'd0, d3_decerr}, 64'd0);
        @(posedge aclk); #1;
        s_bvalid = 1'b0; m_bready = '0;

        // Reset in the middle of master 2's 4-beat burst.
        exp_aw.push_back(aw_exp(2'd2, 4'h3, 32'h0000_3000, 8'd3));
        aw_send(2'd2, 4'h3, 32'h0000_3000, 8'd3);
        push_w(32'h7000, 4, 2);
        w_send(2'd2, 32'h7000, 4, 2);
        aresetn = 1'b0;
        m_wvalid[2] = 1'b1;
        m_awvalid[1] = 1'b1;
        @(negedge aclk);
        chk("reset_midburst", {45'd0, m_awready, m_wready, m_bvalid, s_awvalid, s_wvalid,
                               wfifo_full, b_decerr}, 64'd0);
        @(posedge aclk); #1;
        m_wvalid = '0; m_awvalid = '0;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        exp_aw.push_back(aw_exp(2'd0, 4'h3, 32'h0000_0500, 8'd0));
        push_w(32'h8000, 1, 1);
        aw_send(2'd0, 4'h3, 32'h0000_0500, 8'd0);
        w_send(2'd0, 32'h8000, 1, 1);

`ifdef AXI_ARB_QOS_EN
        // Higher QoS wins over round-robin order.
        m_awqos = {4'd0, 4'd0, 4'd8, 4'd1};
        exp_aw.push_back(aw_exp(2'd1, 4'hB, 32'h0000_0600, 8'd0));
        exp_aw.push_back(aw_exp(2'd0, 4'hC, 32'h0000_0700, 8'd0));
        push_w(32'h9000, 1, 1);
        push_w(32'hA000, 1, 1);
        fork
            aw_send(2'd0, 4'hC, 32'h0000_0700, 8'd0);
            aw_send(2'd1, 4'hB, 32'h0000_0600, 8'd0);
        join
        fork
            w_send(2'd1, 32'h9000, 1, 1);
            w_send(2'd0, 32'hA000, 1, 1);
        join
`endif

        repeat (3) @(posedge aclk);
        chk("aw_queue_empty", 64'(exp_aw.size()), 64'd0);
        chk("w_queue_empty", 64'(exp_w.size()), 64'd0);
        chk("b_queue_empty", 64'(exp_b.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axi4_wr_arbiter.md
Name: axi4_wr_arbiter

Overview:
- N:1 AXI4 write-path arbiter that shares one downstream slave write port among NUM_MASTERS upstream masters.
- Round-robin AW arbitration with a grant held until the AW handshake completes.
- An in-order W-routing FIFO carries the granted master index so W beats follow AW order; B responses route back by the master index prefixed onto the ID.
- Sits between the KAN/TDA compute masters and a single memory-controller slave port, upstream of the system interconnect.

Parameters:
- NUM_MASTERS, 4, number of upstream masters (2..8)
- DATA_WIDTH, 256, W data width
- ADDR_WIDTH, 32, address width
- ID_WIDTH, 4, master-side ID width
- WFIFO_DEPTH, 4, outstanding AW grants whose W data is not yet complete (power of 2)
- Derived: MIDX_W = $clog2(NUM_MASTERS); SID_W = ID_WIDTH + MIDX_W

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- m_awvalid  in  NUM_MASTERS  per-master AW valid
- m_awready  out  NUM_MASTERS  per-master AW ready
- m_awaddr  in  NUM_MASTERS*ADDR_WIDTH  flat-packed, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_awid  in  NUM_MASTERS*ID_WIDTH  flat-packed
- m_awlen  in  NUM_MASTERS*8  flat-packed
- m_awsize  in  NUM_MASTERS*3  flat-packed
- m_awburst  in  NUM_MASTERS*2  flat-packed
- m_wvalid  in  NUM_MASTERS  per-master W valid
- m_wready  out  NUM_MASTERS  per-master W ready
- m_wdata  in  NUM_MASTERS*DATA_WIDTH  flat-packed
- m_wstrb  in  NUM_MASTERS*DATA_WIDTH/8  flat-packed
- m_wlast  in  NUM_MASTERS  per-master W last
- m_bvalid  out  NUM_MASTERS  per-master B valid
- m_bready  in  NUM_MASTERS  per-master B ready
- m_bresp  out  2  broadcast to all masters
- m_bid  out  ID_WIDTH  broadcast to all masters
- s_awvalid/s_awready  out/in  1 each  downstream AW handshake
- s_awaddr  out  ADDR_WIDTH
- s_awid  out  SID_W  {master_idx, m_awid}
- s_awlen  out  8
- s_awsize  out  3
- s_awburst  out  2
- s_wvalid/s_wready  out/in  1 each
- s_wdata  out  DATA_WIDTH
- s_wstrb  out  DATA_WIDTH/8
- s_wlast  out  1
- s_bvalid/s_bready  in/out  1 each
- s_bresp  in  2
- s_bid  in  SID_W
- wfifo_full  out  1  status: W-routing FIFO full
- b_decerr  out  1  one-cycle pulse on a B response with an out-of-range master index

Behaviour:
- Reset values: all m_*ready, m_bvalid, s_*valid, wfifo_full and b_decerr are 0; grant = 0; last_grant = NUM_MASTERS-1; FIFO empty.
- AW FSM state ARB:
  - If any m_awvalid and the FIFO is not full, register grant = first requester after last_grant (cyclic).
  - Go to HOLD.
- AW FSM state HOLD:
  - s_awvalid = m_awvalid[grant]; AW fields muxed from grant; m_awready[grant] = s_awready; all other m_awready = 0.
  - On s_awvalid & s_awready: push grant into the FIFO, set last_grant = grant, go to ARB.
  - If m_awvalid[grant] drops before the handshake (protocol violation), return to ARB without pushing.
- AW latency: s_awvalid asserts exactly 1 cycle after m_awvalid when the arbiter is idle. Minimum spacing between AW grants is 2 cycles.
- W path:
  - When the FIFO is non-empty, head = FIFO[rd].
  - s_wvalid = m_wvalid[head]; W fields muxed from head; m_wready[head] = s_wready; others 0.
  - Pop on s_wvalid & s_wready & s_wlast.
  - FIFO empty: s_wvalid = 0 and all m_wready = 0.
- Simultaneous FIFO push and pop in one cycle is legal and leaves occupancy unchanged.
- A push into an empty FIFO exposes the new head in the following cycle; there is no same-cycle bypass.
- wfifo_full stalls ARB only; a HOLD already in progress completes.
- B path:
  - idx = s_bid[SID_W-1:ID_WIDTH]; m_bvalid[idx] = s_bvalid; s_bready = m_bready[idx].
  - m_bid = s_bid[ID_WIDTH-1:0]; m_bresp = s_bresp.
  - idx >= NUM_MASTERS: s_bready = 1 (response sunk), b_decerr pulses.
  - Purely combinational; zero latency.
- Reset asserted mid-burst: FIFO and FSM clear immediately. In-flight beats are abandoned; the system resets the slave with the same reset.

Optional Feature:
- Macro: AXI_ARB_QOS_EN
- Defined:
  - Adds port m_awqos  in  NUM_MASTERS*4.
  - ARB grants the highest awqos among requesters; ties are broken round-robin from last_grant.
  - Adds output s_awqos = m_awqos[grant].
- Undefined: no QoS ports; pure round-robin.

Decomposition:
- Shared package axi_arb_pkg holds: the AXI burst/resp localparams (BURST_INCR, RESP_OKAY, RESP_DECERR) and a clog2-based MIDX_W helper function.
- One sub-module: axi_arb_wfifo, a synchronous FIFO of MIDX_W-bit entries with full/empty flags.

Test Plan:
- Masters 0 and 2 request AW at once after reset → grants in order 0, 2; s_awid = {2'd0, id} then {2'd2, id}; s_awvalid is seen 1 cycle after request.
- Master 1 AW awlen = 3, then master 3 AW awlen = 0 → s_w beats are 4 from master 1 then 1 from master 3; m_wready[3] stays 0 until master 1's wlast is accepted.
- Issue 4 AWs with s_wready = 0 → wfifo_full = 1; the 5th AW never sees s_awvalid until one burst completes.
- s_bid = {2'd3, 4'hA} with s_bvalid = 1 → m_bvalid = 4'b1000, m_bid = 4'hA. With NUM_MASTERS = 3, s_bid index 3 → s_bready = 1 and b_decerr pulses for 1 cycle.
- Deassert aresetn mid-W burst → all outputs 0 the next edge; after release, a fresh AW from master 0 is granted normally.
- With AXI_ARB_QOS_EN: master 0 qos = 1 and master 1 qos = 8 both request → master 1 granted first.
